// File: rtl/imem_pkg.sv
// Shared constants, state type and PC helpers for the loadable instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP = 32'd0;

  typedef enum logic [1:0] {RUN, LOAD, FAULT} imem_state_t;

  // Word index of a byte address; equivalent to pc[aw+1:2].
  function automatic logic [31:0] pc_to_index(input logic [31:0] pc, input int unsigned aw);
    return (pc >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

  function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned depth);
    return pc < (depth * 4);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x N instruction storage: synchronous write, synchronous read with enable, no reset.
module imem_array #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    // Read register only updates on an accepted fetch, so it holds across stalls and idles.
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a registered, stallable, flushable fetch port.
// Optional bounds/alignment checking is enabled by defining IMEM_BOUNDS_CHECK_EN.
module instr_mem_fetch
  import imem_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [N-1:0]  load_data,
  input  logic          req,
  input  logic [N-1:0]  pc,
  output logic          ready,
  input  logic          stall,
  input  logic          flush,
  output logic [N-1:0]  instruction,
  output logic          valid,
  output logic          fault,
  output logic [31:0]   fetch_count
);

  logic [31:0]   pc32;
  logic [AW-1:0] idx;
  logic          accept;
  logic          bad;
  logic          rd_en;
  logic [N-1:0]  rdata;

  imem_state_t   state_q;
  logic          valid_q;
  logic          fault_q;
  logic          zero_q;
  logic [31:0]   count_q;

  assign pc32 = 32'(pc);
  assign idx  = AW'(pc_to_index(pc32, AW));

`ifdef IMEM_BOUNDS_CHECK_EN
  assign bad = (pc32[1:0] != 2'b00) || !pc_in_range(pc32, DEPTH);
`else
  assign bad = 1'b0;
`endif

  assign ready  = !load_en && (state_q != FAULT) && !fault_q && !(valid_q && stall);
  // A flush in the same cycle drops the request without counting it.
  assign accept = req && ready && !flush;
  assign rd_en  = accept && !bad;

  imem_array #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      zero_q  <= 1'b1;
      count_q <= 32'd0;
    end else if (load_en) begin
      state_q <= LOAD;
      valid_q <= 1'b0;
    end else if (flush) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      zero_q  <= 1'b1;
    end else if (fault_q) begin
      state_q <= FAULT;
    end else if (valid_q && stall) begin
      state_q <= RUN;
    end else if (accept) begin
      state_q <= bad ? FAULT : RUN;
      valid_q <= 1'b1;
      fault_q <= bad;
      zero_q  <= bad;
      count_q <= count_q + 32'd1;
    end else begin
      state_q <= RUN;
      valid_q <= 1'b0;
    end
  end

  // zero_q masks the read register after reset, flush or a faulting accept.
  assign instruction = zero_q ? N'(NOP) : rdata;
  assign valid       = valid_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch with a cycle-level behavioural model.
module tb_instr_mem_fetch;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [N-1:0]  load_data;
  logic          req;
  logic [N-1:0]  pc;
  logic          ready;
  logic          stall;
  logic          flush;
  logic [N-1:0]  instruction;
  logic          valid;
  logic          fault;
  logic [31:0]   fetch_count;

  int tests;
  int failed;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_count;

  instr_mem_fetch #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .req         (req),
    .pc          (pc),
    .ready       (ready),
    .stall       (stall),
    .flush       (flush),
    .instruction (instruction),
    .valid       (valid),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic m_ready();
    return !load_en && !m_fault && !(m_valid && stall);
  endfunction

  function automatic logic m_bad(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
    return (a % 4 != 0) || (a >= DEPTH * 4);
`else
    return (a == 32'hFFFF_FFFF) && (a != a);
`endif
  endfunction

  task automatic drive(input logic r, input logic le, input logic [AW-1:0] la,
                       input logic [31:0] ld, input logic rq, input logic [31:0] p,
                       input logic st, input logic fl);
    rst = r; load_en = le; load_addr = la; load_data = ld;
    req = rq; pc = p; stall = st; flush = fl;
    #1;
  endtask

  // Apply the priority rules to the model, then advance one clock edge.
  task automatic tick();
    int idx;
    if (rst) begin
      m_instr = 32'd0; m_valid = 1'b0; m_fault = 1'b0; m_count = 32'd0;
    end else if (load_en) begin
      m_mem[load_addr] = load_data;
      m_valid = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0; m_instr = 32'd0; m_fault = 1'b0;
    end else if (m_fault || (m_valid && stall)) begin
      m_valid = m_valid;
    end else if (req) begin
      idx = int'((pc >> 2) % DEPTH);
      m_count = m_count + 32'd1;
      m_valid = 1'b1;
      m_fault = m_bad(pc);
      m_instr = m_fault ? 32'd0 : m_mem[idx];
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tests++; if (instruction !== 32'd0) begin failed++; $display("FAIL reset_instr got %h exp 0", instruction); end
    tests++; if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (fault !== 1'b0) begin failed++; $display("FAIL reset_fault got %b exp 0", fault); end
    tests++; if (fetch_count !== 32'd0) begin failed++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
    tests++; if (ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %b exp 1", ready); end
  endtask

  task automatic test_load_fetch();
    logic [31:0] prog [3];
    prog[0] = 32'hE3A00014; prog[1] = 32'hE3A01A01; prog[2] = 32'hE3A02103;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, AW'(i), prog[i], 0, 0, 0, 0); tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 32'(i * 4), 0, 0); tick();
      tests++;
      if (instruction !== prog[i] || valid !== 1'b1) begin
        failed++;
        $display("FAIL fetch_%0d got %h/%b exp %h/1", i, instruction, valid, prog[i]);
      end
    end
    tests++; if (fetch_count !== 32'd3) begin failed++; $display("FAIL fetch_count got %0d exp 3", fetch_count); end
  endtask

  task automatic test_stall();
    logic [31:0] cnt;
    drive(0, 0, 0, 0, 1, 32'd4, 0, 0); tick();
    cnt = fetch_count;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 32'd8, 1, 0);
      tests++; if (ready !== 1'b0) begin failed++; $display("FAIL stall_ready got %b exp 0", ready); end
      tick();
      tests++;
      if (instruction !== 32'hE3A01A01 || valid !== 1'b1 || fetch_count !== 32'd4) begin
        failed++;
        $display("FAIL stall_hold got %h/%b/%0d exp e3a01a01/1/4", instruction, valid, fetch_count);
      end
    end
    drive(0, 0, 0, 0, 1, 32'd8, 0, 0); tick();
    tests++;
    if (instruction !== 32'hE3A02103 || fetch_count !== cnt + 32'd1) begin
      failed++;
      $display("FAIL stall_release got %h/%0d exp e3a02103/%0d", instruction, fetch_count, cnt + 1);
    end
  endtask

  task automatic test_flush();
    drive(0, 0, 0, 0, 1, 32'd0, 1, 1); tick();
    tests++;
    if (valid !== 1'b0 || instruction !== 32'd0 || fetch_count !== 32'd5) begin
      failed++;
      $display("FAIL flush_over_stall got %b/%h/%0d exp 0/0/5", valid, instruction, fetch_count);
    end
  endtask

  task automatic test_load_mid();
    drive(0, 0, 0, 0, 1, 32'd0, 0, 0); tick();
    drive(0, 1, 6'd1, 32'h12345678, 1, 32'd4, 0, 0);
    tests++; if (ready !== 1'b0) begin failed++; $display("FAIL load_ready got %b exp 0", ready); end
    tick();
    tests++; if (valid !== 1'b0) begin failed++; $display("FAIL load_valid got %b exp 0", valid); end
    drive(0, 0, 0, 0, 1, 32'd4, 0, 0); tick();
    tests++;
    if (instruction !== 32'h12345678 || valid !== 1'b1) begin
      failed++;
      $display("FAIL load_refetch got %h/%b exp 12345678/1", instruction, valid);
    end
  endtask

  task automatic test_bounds();
`ifdef IMEM_BOUNDS_CHECK_EN
    drive(0, 0, 0, 0, 1, 32'd2, 0, 0); tick();
    tests++;
    if (fault !== 1'b1 || instruction !== 32'd0 || valid !== 1'b1) begin
      failed++;
      $display("FAIL misalign got %b/%h/%b exp 1/0/1", fault, instruction, valid);
    end
    drive(0, 0, 0, 0, 1, 32'd0, 0, 0);
    tests++; if (ready !== 1'b0) begin failed++; $display("FAIL fault_ready got %b exp 0", ready); end
    tick();
    tests++; if (fault !== 1'b1) begin failed++; $display("FAIL fault_sticky got %b exp 1", fault); end
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
    tests++; if (fault !== 1'b0) begin failed++; $display("FAIL fault_flush got %b exp 0", fault); end
    drive(0, 0, 0, 0, 1, 32'd256, 0, 0); tick();
    tests++; if (fault !== 1'b1) begin failed++; $display("FAIL oob_fault got %b exp 1", fault); end
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
`else
    drive(0, 0, 0, 0, 1, 32'd256, 0, 0); tick();
    tests++;
    if (instruction !== 32'hE3A00014 || fault !== 1'b0) begin
      failed++;
      $display("FAIL oob_wrap got %h/%b exp e3a00014/0", instruction, fault);
    end
`endif
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 0, 1, 32'd8, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 32'd4, 1, 0); tick();
    drive(1, 0, 0, 0, 1, 32'd4, 1, 0); tick();
    tests++;
    if (valid !== 1'b0 || fetch_count !== 32'd0 || fault !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid got %b/%0d/%b exp 0/0/0", valid, fetch_count, fault);
    end
    drive(0, 0, 0, 0, 1, 32'd0, 0, 0); tick();
    tests++;
    if (instruction !== 32'hE3A00014 || fetch_count !== 32'd1) begin
      failed++;
      $display("FAIL reset_keep_mem got %h/%0d exp e3a00014/1", instruction, fetch_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] p;
    logic        r, le, rq, st, fl;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, AW'(i), $urandom, 0, 0, 0, 0); tick();
    end
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(99, 0) < 2);
      le = ($urandom_range(99, 0) < 5);
      fl = ($urandom_range(99, 0) < 10);
      st = ($urandom_range(99, 0) < 30);
      rq = ($urandom_range(99, 0) < 75);
      case ($urandom_range(9, 0))
        0:       p = 32'($urandom_range(DEPTH * 4 - 1, 0)) | 32'd1;
        1:       p = 32'($urandom_range(DEPTH * 8, DEPTH * 4));
        default: p = 32'($urandom_range(DEPTH - 1, 0)) * 4;
      endcase
      drive(r, le, AW'($urandom), $urandom, rq, p, st, fl);
      tests++;
      if (ready !== m_ready()) begin
        failed++;
        $display("FAIL rand_ready cyc %0d got %b exp %b", c, ready, m_ready());
      end
      tick();
      tests++;
      if ({instruction, valid, fault, fetch_count} !== {m_instr, m_valid, m_fault, m_count}) begin
        failed++;
        $display("FAIL rand_out cyc %0d got %h/%b/%b/%0d exp %h/%b/%b/%0d", c, instruction,
                 valid, fault, fetch_count, m_instr, m_valid, m_fault, m_count);
      end
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    m_instr = 32'd0; m_valid = 1'b0; m_fault = 1'b0; m_count = 32'd0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_fetch();
    test_stall();
    test_flush();
    test_load_mid();
    test_bounds();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, loadable instruction memory with a registered fetch port.
- Successor to the fixed combinational program ROM: depth and width are set by parameters, and the program is written through a load port instead of being hard-coded.
- Read has 1-cycle latency and a req/ready/valid handshake with stall and flush for the pipelined ARM-subset core.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- N, 32, instruction/data word width in bits.
- DEPTH, 64, number of instruction words; power of two, ≥4.
- AW, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- load_en  in  1  program-load write strobe.
- load_addr  in  AW  word index written when load_en=1.
- load_data  in  N  word written.
- req  in  1  fetch request.
- pc  in  N  byte address of the fetch.
- ready  out  1  fetch accepted this cycle when req&&ready.
- stall  in  1  downstream not ready; hold the current output.
- flush  in  1  discard the current output (branch taken).
- instruction  out  N  fetched word, registered.
- valid  out  1  instruction is meaningful.
- fault  out  1  out-of-range or misaligned fetch (see optional feature).
- fetch_count  out  32  number of accepted fetches.

Behaviour:
- Reset values: instruction=0 (NOP encoding 0), valid=0, fault=0, fetch_count=0, state=RUN.
- Memory contents are not cleared by rst, so a loaded program survives reset.
- Word index is pc[AW+1:2].
- States are RUN, LOAD and FAULT; the state is recomputed every cycle.
  - LOAD while load_en=1.
  - RUN → FAULT on a faulting accept.
  - FAULT → RUN only on flush or rst.
- Priority order: rst > load_en > flush > stall > req.
- ready is combinational: ready = !load_en && state!=FAULT && !(valid && stall).
- Load:
  - Each cycle with load_en=1: mem[load_addr] <= load_data at the edge, and valid <= 0.
  - Loading in the middle of an output invalidates that output.
- Fetch accept (req && ready): at the next edge, instruction <= mem[index], valid <= 1, fetch_count += 1. fetch_count wraps 2^32-1 → 0.
- No request (ready=1, req=0): valid <= 0 next edge; instruction keeps its last value.
- Stall (valid && stall && !flush): instruction, valid and fetch_count hold; req is ignored.
- Flush:
  - Next edge: valid <= 0, instruction <= 0, fault <= 0.
  - A req in the same cycle is dropped and not counted.
  - Flush overrides stall.
- Read-during-load to the same index: load_en blocks fetch, so there is no hazard.
- Read of a word loaded on the previous cycle returns the new data.

Optional Feature:
- Macro IMEM_BOUNDS_CHECK_EN.
- Defined:
  - An accept with pc[1:0]!=0 or pc >= DEPTH*4 produces instruction=0, valid=1, fault=1, and enters FAULT.
  - fault stays sticky and ready=0 until flush or rst.
  - fetch_count still increments for the faulting accept.
- Undefined:
  - fault is tied to 0 and the FAULT state is unreachable.
  - pc[1:0] is ignored and the index wraps modulo DEPTH (pc = DEPTH*4 reads word 0).

Decomposition:
- Package imem_pkg holds:
  - localparam NOP = 32'd0;
  - typedef enum {RUN, LOAD, FAULT} imem_state_t;
  - function pc_to_index(pc) returning pc[AW+1:2];
  - function pc_in_range(pc, depth).
- One sub-module, imem_array: DEPTH×N storage with a synchronous write port and a synchronous read port, no reset.
- Handshake, FSM and counter logic live in instr_mem_fetch.

Test Plan:
- Load and fetch: load words 0..2 = 0xE3A00014, 0xE3A01A01, 0xE3A02103; rst; req with pc=0,4,8 on consecutive cycles → instruction shows those three values on cycles 1, 2, 3 with valid=1; fetch_count=3.
- Stall: with valid=1 showing 0xE3A01A01, assert stall for 3 cycles with req=1 and pc=8 → output held, ready=0, fetch_count unchanged; release stall → 0xE3A02103 on the next cycle.
- Flush over stall: valid=1, stall=1, flush=1, req=1 → next cycle valid=0, instruction=0, fetch_count unchanged.
- Load mid-output: valid=1, then load_en=1 writing word 1 = 0x12345678 → valid=0 and ready=0 during the load; afterwards fetch pc=4 → 0x12345678.
- Bounds with IMEM_BOUNDS_CHECK_EN defined, DEPTH=64:
  - pc=2 → fault=1, instruction=0, ready=0 held until flush;
  - pc=256 → fault=1.
  - Without the macro, pc=256 returns word 0 and fault stays 0.
- Reset mid-operation: rst during a stall with valid=1 → next cycle valid=0, fetch_count=0, state RUN; a fetch of pc=0 still returns the previously loaded word 0.
